// File: rtl/fp_pkg.sv
// fp_normalizer shared types
// constants, FSM state, flag indices, operand bundle
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = FRAC_W + 2;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam int BIAS = 127;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp_operand_t;

endpackage

// File: rtl/fp_normalizer_if.sv
// fp_normalizer handshake bundle
// master drives operands, slave is the normalizer
interface fp_normalizer_if
  import fp_pkg::*;
();

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [MANT_W-1:0] in_mant;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       Result;
  logic [3:0]        ALUFlags;

  modport master (
    output in_valid,
    output in_sign,
    output in_exp,
    output in_mant,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  Result,
    input  ALUFlags
  );

  modport slave (
    input  in_valid,
    input  in_sign,
    input  in_exp,
    input  in_mant,
    input  out_ready,
    output in_ready,
    output out_valid,
    output Result,
    output ALUFlags
  );

endinterface

// File: rtl/fp_normalizer.sv
// fp_normalizer: post-add renormalization
// one shift per cycle, packs IEEE word + NZCV
module fp_normalizer
  import fp_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  fp_normalizer_if.slave bus
);

  state_e              state_q, state_d;
  logic                sign_q, sign_d;
  logic [EXP_W:0]      exp_q, exp_d;
  logic [MANT_W-1:0]   mant_q, mant_d;
  logic                c_q, c_d;
  logic [31:0]         res_q, res_d;
  logic [3:0]          flg_q, flg_d;
  logic                zero_d;
  logic                ovf_d;
  logic                fin;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // operand/result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sign_q <= 1'b0;
      exp_q  <= '0;
      mant_q <= '0;
      c_q    <= 1'b0;
      res_q  <= '0;
      flg_q  <= '0;
    end else begin
      sign_q <= sign_d;
      exp_q  <= exp_d;
      mant_q <= mant_d;
      c_q    <= c_d;
      res_q  <= res_d;
      flg_q  <= flg_d;
    end
  end

  // datapath: load, single-step shift, pack on finish
  always_comb begin
    sign_d = sign_q;
    exp_d  = exp_q;
    mant_d = mant_q;
    c_d    = c_q;
    res_d  = res_q;
    flg_d  = flg_q;
    zero_d = 1'b0;
    ovf_d  = 1'b0;
    fin    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d = bus.in_sign;
          c_d    = bus.in_mant[MANT_W-1];
          exp_d  = {1'b0, bus.in_exp};
          mant_d = bus.in_mant;
          if (bus.in_mant == '0 || bus.in_exp == '0) begin
            zero_d = 1'b1;
            fin    = 1'b1;
          end else if (bus.in_mant[MANT_W-1]) begin
            mant_d = bus.in_mant >> 1;
            exp_d  = {1'b0, bus.in_exp} + 9'd1;
            ovf_d  = exp_d >= {1'b0, EXP_MAX};
            fin    = 1'b1;
          end else if (bus.in_mant[MANT_W-2]) begin
            fin = 1'b1;
          end
        end
      end
      SHIFT: begin
        // exp==1 means one more shift would go denormal
        if (exp_q == 9'd1) begin
          zero_d = 1'b1;
          fin    = 1'b1;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - 9'd1;
          fin    = mant_d[MANT_W-2];
        end
      end
      default: ;
    endcase
    if (fin) begin
      if (zero_d)
        res_d = 32'h0;
      else if (ovf_d)
        res_d = {sign_d, EXP_MAX, {FRAC_W{1'b0}}};
      else
        res_d = {sign_d, exp_d[EXP_W-1:0],
                 mant_d[FRAC_W-1:0]};
      flg_d[FLAG_N] = sign_d & ~zero_d;
      flg_d[FLAG_Z] = zero_d;
      flg_d[FLAG_C] = c_d;
      flg_d[FLAG_V] = ovf_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)
                 state_d = fin ? DONE : SHIFT;
      SHIFT:   if (fin) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // handshake and result outputs
  always_comb begin
    bus.in_ready  = (state_q == IDLE) & ~reset;
    bus.out_valid = (state_q == DONE);
    bus.Result    = res_q;
    bus.ALUFlags  = flg_q;
  end

endmodule

// File: tb/tb_fp_normalizer.sv
// fp_normalizer bench
// directed vectors, hand-computed results
module tb_fp_normalizer;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  fp_normalizer_if bus ();

  fp_normalizer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] want);
    n_chk++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got %h want %h",
                  tag, obs, want);
  endtask

  task automatic run(string tag, logic s,
                     logic [7:0] e, logic [24:0] m,
                     logic [31:0] wres, logic [3:0] wflg,
                     int wlat, int hold);
    int   lat;
    logic busy;
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(bus.in_ready), 1);
    bus.in_sign  = s;
    bus.in_exp   = e;
    bus.in_mant  = m;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat  = 0;
    busy = 1'b0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid || lat >= 40) break;
      if (bus.in_ready) busy = 1'b1;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(wlat));
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_res"}, bus.Result, wres);
    chk({tag, "_flg"}, 32'(bus.ALUFlags), 32'(wflg));
    chk({tag, "_nrdy"}, 32'(bus.in_ready), 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hres"}, bus.Result, wres);
      chk({tag, "_hvld"}, 32'(bus.out_valid), 1);
      chk({tag, "_hrdy"}, 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_drop"}, 32'(bus.out_valid), 0);
  endtask

  initial begin
    n_chk         = 0;
    n_pass        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_mant   = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_vld", 32'(bus.out_valid), 0);
    chk("rst_res", bus.Result, 0);
    chk("rst_flg", 32'(bus.ALUFlags), 0);
    chk("rst_rdy", 32'(bus.in_ready), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rdy1", 32'(bus.in_ready), 1);

    run("noshift", 0, 8'h80, 25'h0C00000,
        32'h40400000, 4'b0000, 1, 0);
    run("neg", 1, 8'h80, 25'h0C00000,
        32'hC0400000, 4'b1000, 1, 0);
    run("carry", 0, 8'h80, 25'h1000000,
        32'h40800000, 4'b0010, 1, 0);
    run("carry2", 0, 8'h7F, 25'h1800000,
        32'h40400000, 4'b0010, 1, 0);
    run("cancel", 1, 8'h85, 25'h0200000,
        32'hC1800000, 4'b1000, 3, 0);
    run("shift23", 0, 8'h90, 25'h0000001,
        32'h3C800000, 4'b0000, 24, 0);
    run("zero", 0, 8'h80, 25'h0000000,
        32'h00000000, 4'b0100, 1, 0);
    run("nzero", 1, 8'h80, 25'h0000000,
        32'h00000000, 4'b0100, 1, 0);
    run("exp0", 1, 8'h00, 25'h0C00000,
        32'h00000000, 4'b0100, 1, 0);
    run("flush", 0, 8'h02, 25'h0000001,
        32'h00000000, 4'b0100, 3, 0);
    run("ovf", 0, 8'hFE, 25'h1000000,
        32'h7F800000, 4'b0011, 1, 0);
    run("bp", 0, 8'h80, 25'h0C00000,
        32'h40400000, 4'b0000, 1, 5);

    // in_valid during DONE handshake is taken a cycle later
    @(negedge clk);
    bus.in_sign  = 1'b0;
    bus.in_exp   = 8'h80;
    bus.in_mant  = 25'h1000000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("sim_vld0", 32'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    bus.in_sign   = 1'b1;
    bus.in_exp    = 8'h80;
    bus.in_mant   = 25'h0C00000;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("sim_idle", 32'(bus.out_valid), 0);
    chk("sim_rdy", 32'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("sim_vld1", 32'(bus.out_valid), 1);
    chk("sim_res", bus.Result, 32'hC0400000);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("sim_drop", 32'(bus.out_valid), 0);

    // reset while shifting discards the operation
    bus.in_sign  = 1'b0;
    bus.in_exp   = 8'h90;
    bus.in_mant  = 25'h0000001;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mid_busy", 32'(bus.in_ready), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_vld", 32'(bus.out_valid), 0);
    chk("mid_rdy0", 32'(bus.in_ready), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rdy1", 32'(bus.in_ready), 1);
    repeat (30) @(negedge clk);
    chk("mid_quiet", 32'(bus.out_valid), 0);

    run("post", 0, 8'h80, 25'h0C00000,
        32'h40400000, 4'b0000, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
